// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1-style UART transmitter that drains a first-word-fall-through
// TX FIFO. The FSM pops a word whenever the FIFO is non-empty and the line is
// free (or the current stop bit is ending), then shifts it out LSB first.
// Bit timing comes from an internal 16x oversampling tick generator that is
// re-phased on every pop, so each frame is aligned to its own pop cycle.
//
// FIFO read handshake: the FIFO presents a valid head word on rd_data in every
// cycle where empty=0. A transfer happens in exactly the cycle where rd=1; rd is
// only ever raised when empty=0, and the word on rd_data in that cycle is the
// one transmitted. There is no other flow control.

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [1:0]            fsm_state
);

    // Derived timing: clocks per 16x tick, and the resulting width of the counter.
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    // Counter value one clock before a tick; with TICK_DIV=1 every clock ticks.
    localparam logic [TW-1:0] TICK_PRE = TW'((TICK_DIV > 1) ? (TICK_DIV - 2) : 0);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    logic [TW-1:0]         tick_cnt;
    logic [3:0]            tick_count;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_shift;
    logic                  tick;
    logic                  tick_next;
    logic                  stop_end;
    logic                  done_next;

    // Tick strobes: one on the wrapping clock, one on the clock just before it.
    assign tick      = (tick_cnt == TICK_MAX);
    assign tick_next = (TICK_DIV == 1) ? 1'b1 : (tick_cnt == TICK_PRE);

    // Sixteenth tick of the stop bit: the frame ends and a new pop may happen.
    assign stop_end  = (state == STOP) && tick && (tick_count == 4'd15);

    // tx_done is registered, so it is armed one clock ahead of the stop-bit end.
    assign done_next = (state == STOP) && tick_next && (tick_count == 4'd15);

    // Pop strobe: free line or ending stop bit, FIFO has data, never in reset.
    assign rd = ~reset & ~empty & ((state == IDLE) | stop_end);

    assign fsm_state = state;

    // Next shift register contents after a data bit completes.
    always_comb begin
        shreg_shift = shreg >> 1;
    end

    // 16x tick generator, cleared on each pop to phase-align the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (rd) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tick_count <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
        end else begin
            tx_done <= done_next;
            if (rd) begin
                // Latch the head word and drive the start bit from the next clock.
                shreg      <= rd_data;
                state      <= START;
                tx         <= 1'b0;
                tx_busy    <= 1'b1;
                tick_count <= '0;
                bit_idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (tick) begin
                            if (tick_count == 4'd15) begin
                                tick_count <= '0;
                                bit_idx    <= '0;
                                state      <= DATA;
                                tx         <= shreg[0];
                            end else begin
                                tick_count <= tick_count + 4'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (tick_count == 4'd15) begin
                                tick_count <= '0;
                                shreg      <= shreg_shift;
                                if (bit_idx == BIT_LAST) begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                    tx      <= shreg_shift[0];
                                end
                            end else begin
                                tick_count <= tick_count + 4'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (tick_count == 4'd15) begin
                                // No pop this cycle, so the line goes idle.
                                tick_count <= '0;
                                state      <= IDLE;
                                tx         <= 1'b1;
                                tx_busy    <= 1'b0;
                            end else begin
                                tick_count <= tick_count + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
